flex_updown_counter: RTL and testbench

Parametrised up/down counter with a programmable step, a wrap or saturate mode, a synchronous load and registered terminal flags. It extends the team's basic increment-by-1 rollover counter and keeps that counter's behaviour at step=1, direction up, wrap mode. Timers, packet-length trackers and FIFO pointer logic in later labs instantiate it where they need loadable, bidirectional or strided counting.

---
 rtl/flex_updown_counter.sv | 77 +++++++
 tb/tb_flex_updown_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/flex_updown_counter.sv
// flex_updown_counter: loadable up/down counter with programmable step, wrap/saturate bound and registered flags
module flex_updown_counter #(
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    dir,
  input  logic                    sat_mode,
  input  logic [NUM_CNT_BITS-1:0] step,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    zero_flag,
  output logic                    wrap_pulse,
  output logic                    cfg_err
);
  localparam int W = NUM_CNT_BITS;
  logic [W-1:0] count_q, count_d;
  logic         roll_q, roll_d, zero_q, zero_d, wrap_q, wrap_d, err_q, err_d;
  logic [W:0]   c, s, r, sum;
  logic         bad, wr;
  // Next count, flags and wrap pulse; one bit of headroom keeps sums exact
  always_comb begin
    c = {1'b0, count_q};
    s = {1'b0, step};
    r = {1'b0, rollover_val};
    sum = c + s;
    bad = (r == '0) | (s == '0) | (s > r);
    wr = clear | load | count_enable;
    count_d = count_q;
    wrap_d = 1'b0;
    if (clear) count_d = '0;
    else if (load) count_d = (load_val > rollover_val) ? rollover_val : load_val;
    else if (count_enable && !bad) begin
      if (c > r) count_d = rollover_val;
      else if (dir) begin
        if (sum > r) begin
          count_d = sat_mode ? rollover_val : W'(sum - r);
          wrap_d = !sat_mode;
        end else count_d = W'(sum);
      end else begin
        if (c <= s) begin
          count_d = sat_mode ? '0 : W'(c + r - s);
          wrap_d = !sat_mode;
        end else count_d = W'(c - s);
      end
    end
    roll_d = wr ? (count_d == rollover_val) : roll_q;
    zero_d = wr ? (count_d == '0) : zero_q;
    err_d = bad;
  end
  // State register with asynchronous active-low reset clearing every output
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      roll_q  <= 1'b0;
      zero_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
      zero_q  <= zero_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end
  assign count_out     = count_q;
  assign rollover_flag = roll_q;
  assign zero_flag     = zero_q;
  assign wrap_pulse    = wrap_q;
  assign cfg_err       = err_q;
endmodule

// File: tb/tb_flex_updown_counter.sv
// tb_flex_updown_counter: directed vectors checked against an integer reference model and literal expectations
module tb_flex_updown_counter;
  logic       clk = 1'b0;
  logic       n_rst, clear, load, count_enable, dir, sat_mode;
  logic [7:0] load_val, step, rollover_val;
  logic [7:0] count_out;
  logic       rollover_flag, zero_flag, wrap_pulse, cfg_err;
  int n_cmp = 0, n_bad = 0;
  int m_cnt, m_roll, m_zero, m_wrap, m_err;
  bit done = 0;

  flex_updown_counter #(.NUM_CNT_BITS(8)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .dir(dir), .sat_mode(sat_mode), .step(step),
    .rollover_val(rollover_val), .count_out(count_out), .rollover_flag(rollover_flag),
    .zero_flag(zero_flag), .wrap_pulse(wrap_pulse), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic over the counting rules
  always @(posedge clk or negedge n_rst) begin
    int c, s, r, n, w, b;
    if (!n_rst) begin
      m_cnt = 0; m_roll = 0; m_zero = 0; m_wrap = 0; m_err = 0;
    end else begin
      c = m_cnt; s = step; r = rollover_val; n = c; w = 0;
      b = (r == 0 || s == 0 || s > r) ? 1 : 0;
      if (clear) n = 0;
      else if (load) n = (load_val < r) ? int'(load_val) : r;
      else if (count_enable && b == 0) begin
        if (c > r) n = r;
        else if (sat_mode) n = dir ? ((c + s < r) ? c + s : r) : ((c <= s) ? 0 : c - s);
        else if (dir) begin
          n = c + s;
          if (n > r) begin n = n - r; w = 1; end
        end else begin
          n = c - s;
          if (n <= 0) begin n = n + r; w = 1; end
        end
      end
      if (clear || load || count_enable) begin
        m_roll = (n == r) ? 1 : 0;
        m_zero = (n == 0) ? 1 : 0;
      end
      m_cnt = n; m_wrap = w; m_err = b;
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    while (!done) begin
      @(posedge clk);
      #1;
      if (!done) begin
        chk("model_count", count_out, m_cnt);
        chk("model_roll", rollover_flag, m_roll);
        chk("model_zero", zero_flag, m_zero);
        chk("model_wrap", wrap_pulse, m_wrap);
        chk("model_err", cfg_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int e1[12] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
  int e2[4] = '{1, 8, 5, 2};
  int e3u[5] = '{60, 120, 180, 200, 200};
  int e3d[5] = '{140, 80, 20, 0, 0};

  initial begin
    n_rst = 0; clear = 0; load = 0; count_enable = 0; dir = 1; sat_mode = 0;
    load_val = 0; step = 1; rollover_val = 5;
    @(negedge clk); @(negedge clk);
    chk("rst_count", count_out, 0);
    chk("rst_roll", rollover_flag, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_wrap", wrap_pulse, 0);
    chk("rst_err", cfg_err, 0);
    n_rst = 1;
    // basic up wrap
    clear = 1; tick(); clear = 0;
    chk("clr_zero", zero_flag, 1);
    count_enable = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_count", count_out, e1[i]);
      chk("up_roll", rollover_flag, e1[i] == 5);
      chk("up_wrap", wrap_pulse, (i == 5 || i == 10) ? 1 : 0);
    end
    // strided down wrap
    count_enable = 0; rollover_val = 10; load = 1; load_val = 4; tick(); load = 0;
    chk("ld_count", count_out, 4);
    step = 3; dir = 0; count_enable = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dn_count", count_out, e2[i]);
      chk("dn_wrap", wrap_pulse, (i == 1) ? 1 : 0);
    end
    // saturate both directions
    count_enable = 0; clear = 1; tick(); clear = 0;
    rollover_val = 200; step = 60; sat_mode = 1; dir = 1; count_enable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("satu_count", count_out, e3u[i]);
      chk("satu_roll", rollover_flag, (i >= 3) ? 1 : 0);
      chk("satu_wrap", wrap_pulse, 0);
    end
    dir = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("satd_count", count_out, e3d[i]);
      chk("satd_zero", zero_flag, (i >= 3) ? 1 : 0);
      chk("satd_wrap", wrap_pulse, 0);
    end
    // priority and clamp
    sat_mode = 0; dir = 1; step = 1; rollover_val = 100;
    clear = 1; load = 1; load_val = 50; count_enable = 1; tick();
    chk("prio_count", count_out, 0);
    clear = 0; count_enable = 0; load_val = 250; tick(); load = 0;
    chk("clamp_count", count_out, 100);
    chk("clamp_roll", rollover_flag, 1);
    // config error then out-of-range recovery
    rollover_val = 10; load = 1; load_val = 7; tick(); load = 0;
    rollover_val = 5; step = 6; count_enable = 1; tick();
    chk("cfg_hold", count_out, 7);
    chk("cfg_err", cfg_err, 1);
    step = 2; tick();
    chk("oor_count", count_out, 5);
    chk("oor_wrap", wrap_pulse, 0);
    chk("oor_err", cfg_err, 0);
    tick();
    chk("oor_wrap_count", count_out, 2);
    chk("oor_wrap_pulse", wrap_pulse, 1);
    // async reset mid-count
    count_enable = 0; clear = 1; tick(); clear = 0;
    step = 1; count_enable = 1; tick(); tick(); tick();
    chk("pre_rst_count", count_out, 3);
    count_enable = 0;
    #2 n_rst = 0;
    #1;
    chk("arst_count", count_out, 0);
    chk("arst_roll", rollover_flag, 0);
    chk("arst_zero", zero_flag, 0);
    chk("arst_wrap", wrap_pulse, 0);
    chk("arst_err", cfg_err, 0);
    @(negedge clk);
    n_rst = 1; count_enable = 1; tick();
    chk("post_rst_count", count_out, 1);
    count_enable = 0; tick();
    done = 1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
